// File: rtl/mips_lsu_pkg.sv
// Shared types and constants for the mips_lsu_mem load/store unit.
package mips_lsu_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   // Request fields latched at accept (address kept separately: width is parametric)
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/mips_lsu_mem_lane.sv
// Byte-lane extract/extend, store merge and alignment check.
// Sub-word paths exist only when MIPS_LSU_SUBWORD_EN is defined.
module mips_lsu_mem_lane
   import mips_lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [31:0] o_rdata_c,
   output logic [31:0] o_merged_c,
   output logic        o_aligned_c
);

`ifdef MIPS_LSU_SUBWORD_EN
   logic [4:0]  w_amt;
   logic [31:0] w_sh;
   logic [31:0] w_mask;

   assign w_amt = {i_lane, 3'b000};
   assign w_sh  = i_word >> w_amt;

   always_comb begin
      o_aligned_c = 1'b0;
      o_rdata_c   = i_word;
      w_mask      = 32'hFFFF_FFFF;
      case (i_size)
         SZ_BYTE: begin
            o_aligned_c = 1'b1;
            o_rdata_c   = {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
            w_mask      = 32'h0000_00FF << w_amt;
         end
         SZ_HALF: begin
            o_aligned_c = ~i_lane[0];
            o_rdata_c   = {{16{i_signed & w_sh[15]}}, w_sh[15:0]};
            w_mask      = 32'h0000_FFFF << w_amt;
         end
         SZ_WORD: begin
            o_aligned_c = (i_lane == 2'b00);
         end
         default: begin
            o_aligned_c = 1'b0;
         end
      endcase
      // Only the addressed lanes take the (shifted) low bits of wdata
      o_merged_c = (i_word & ~w_mask) | ((i_wdata << w_amt) & w_mask);
   end
`else
   logic w_unused_sgn;

   assign w_unused_sgn = i_signed;
   assign o_aligned_c  = (i_size == SZ_WORD) && (i_lane == 2'b00);
   assign o_rdata_c    = i_word;
   assign o_merged_c   = i_wdata;
`endif

endmodule

// File: rtl/mips_lsu_mem.sv
// MEM-stage load/store unit with wait-stated data memory and valid/ready handshake.
// Byte/halfword support is enabled by defining MIPS_LSU_SUBWORD_EN.
module mips_lsu_mem
   import mips_lsu_pkg::*;
#(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned ADDR_W   = $clog2(DEPTH) + 2,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IDX_W = ADDR_W - 2;

   logic [31:0] mem [DEPTH];

   lsu_state_e        r_state;
   lsu_state_e        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   lsu_req_t          r_req;
   logic [ADDR_W-1:0] r_addr;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;

   logic              w_accept;
   logic              w_access;
   logic              w_idle;
   logic [ADDR_W-1:0] w_sel_addr;
   lsu_req_t          w_sel_req;
   logic [IDX_W-1:0]  w_idx;
   logic [31:0]       w_word;
   logic [31:0]       w_rdata;
   logic [31:0]       w_merged;
   logic              w_aligned;

   // In IDLE the lane logic judges the incoming request; afterwards the latched one
   assign w_idle     = (r_state == IDLE);
   assign w_sel_addr = w_idle ? req_addr : r_addr;
   assign w_sel_req  = w_idle ? '{we: req_we, size: req_size, sgn: req_signed, wdata: req_wdata}
                              : r_req;
   assign w_idx      = w_sel_addr[ADDR_W-1:2];
   assign w_word     = mem[w_idx];

   mips_lsu_mem_lane u_lane (
      .i_word      (w_word),
      .i_wdata     (w_sel_req.wdata),
      .i_lane      (w_sel_addr[1:0]),
      .i_size      (w_sel_req.size),
      .i_signed    (w_sel_req.sgn),
      .o_rdata_c   (w_rdata),
      .o_merged_c  (w_merged),
      .o_aligned_c (w_aligned)
   );

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid && r_req_ready) begin
               w_accept = 1'b1;
               if (w_aligned) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_W'(WAIT_CYC);
               end else begin
                  w_state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_access    = 1'b1;
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_req       <= '0;
         r_addr      <= '0;
      end else begin
         r_req_ready <= (w_state_nxt == IDLE);
         r_rsp_valid <= (w_state_nxt == RESP);
         if (w_accept) begin
            r_req  <= w_sel_req;
            r_addr <= req_addr;
         end
         if (w_accept && !w_aligned) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
         end else if (w_access) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_req.we ? 32'h0 : w_rdata;
         end
      end
   end

   // Memory has no reset; a store coinciding with reset is dropped
   always_ff @(posedge clk1) begin
      if (rst_n && w_access && r_req.we) begin
         mem[w_idx] <= w_merged;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
